// File: rtl/my_mem_pkg.sv
// Shared types and helpers for the parity memory responder.
// Words are stored as {even parity, data}.
package my_mem_pkg;

    localparam int DATA_W = 8;
    localparam int WORD_W = 9;

    typedef logic [WORD_W-1:0] mem_word_t;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        ERR
    } resp_state_t;

    function automatic mem_word_t make_word(input logic [DATA_W-1:0] d);
        return {^d, d};
    endfunction

endpackage

// File: rtl/parity_mem_array.sv
// Parity word storage with registered read port.
// Written flags clear asynchronously; storage itself is never reset.
module parity_mem_array
    import my_mem_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  mem_word_t         wdata,
    output mem_word_t         rdata,
    output logic              rwritten
);

    localparam int DEPTH = 2 ** ADDR_W;

    mem_word_t        mem [DEPTH];
    logic [DEPTH-1:0] written;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written  <= '0;
            rwritten <= 1'b0;
        end else begin
            if (we) written[addr] <= 1'b1;
            if (re) rwritten <= written[addr];
        end
    end

endmodule

// File: rtl/parity_mem_responder.sv
// Responder for the parity-memory read/write interface.
// Optional stored-parity checking enabled by PARITY_CHECK_EN.
module parity_mem_responder
    import my_mem_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write,
    input  logic                 read,
    input  logic [ADDR_W-1:0]    address,
    input  logic [DATA_W-1:0]    data_in,
`ifdef PARITY_CHECK_EN
    input  logic                 par_inject,
    output logic                 par_err,
`endif
    output logic [WORD_W-1:0]    data_out,
    output logic                 rd_valid,
    output logic                 uninit_rd,
    output logic                 prot_err,
    output logic [ERR_CNT_W-1:0] error_count
);

    resp_state_t state_q, state_d;

    logic      cmd_wr, cmd_rd;
    mem_word_t wword, rword;
    logic      rwritten;
    logic      par_bad;

    mem_word_t dout_d;
    logic      valid_d, uninit_d, prot_d, inc_d;

    assign cmd_wr = write & ~read;
    assign cmd_rd = read & ~write;

`ifdef PARITY_CHECK_EN
    assign wword   = make_word(data_in) ^ {par_inject, 8'h00};
    assign par_bad = rwritten && ((^rword[DATA_W-1:0]) != rword[DATA_W]);
`else
    assign wword   = make_word(data_in);
    assign par_bad = 1'b0;
`endif

    parity_mem_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we      (cmd_wr),
        .re      (cmd_rd),
        .addr    (address),
        .wdata   (wword),
        .rdata   (rword),
        .rwritten(rwritten)
    );

    always_comb begin
        state_d  = IDLE;
        dout_d   = data_out;
        valid_d  = 1'b0;
        uninit_d = 1'b0;
        prot_d   = 1'b0;
        inc_d    = 1'b0;
        if (write && read) state_d = ERR;
        else if (read)     state_d = RESP;
        unique case (state_q)
            RESP: begin
                valid_d  = 1'b1;
                uninit_d = ~rwritten;
                dout_d   = rwritten ? rword : '0;
                inc_d    = par_bad;
            end
            ERR: begin
                prot_d = 1'b1;
                inc_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            data_out    <= '0;
            rd_valid    <= 1'b0;
            uninit_rd   <= 1'b0;
            prot_err    <= 1'b0;
            error_count <= '0;
        end else begin
            state_q   <= state_d;
            data_out  <= dout_d;
            rd_valid  <= valid_d;
            uninit_rd <= uninit_d;
            prot_err  <= prot_d;
            // Saturate rather than wrap so a long soak never hides errors
            if (inc_d && error_count != '1)
                error_count <= error_count + ERR_CNT_W'(1);
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_err <= 1'b0;
        else     par_err <= (state_q == RESP) && par_bad;
    end
`endif

endmodule

// File: tb/tb_parity_mem_responder.sv
// Self-checking bench for parity_mem_responder.
// Random and directed traffic against an associative-array memory model.
module tb_parity_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        write, read;
    logic [15:0] address;
    logic [7:0]  data_in;
    logic [8:0]  data_out;
    logic        rd_valid, uninit_rd, prot_err;
    logic [15:0] error_count;
`ifdef PARITY_CHECK_EN
    logic        par_inject;
    logic        par_err;
`endif

    int errs = 0;
    int nchk = 0;

    logic [8:0]  mdl [int];
    logic [15:0] exp_err;

    parity_mem_responder #(
        .ADDR_W   (16),
        .ERR_CNT_W(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .write      (write),
        .read       (read),
        .address    (address),
        .data_in    (data_in),
`ifdef PARITY_CHECK_EN
        .par_inject (par_inject),
        .par_err    (par_err),
`endif
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .uninit_rd  (uninit_rd),
        .prot_err   (prot_err),
        .error_count(error_count)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] good_word(input logic [7:0] d);
        logic p;
        p = ($countones(d) % 2) == 1;
        return {p, d};
    endfunction

    function automatic logic [8:0] model_rd(input logic [15:0] a);
        if (mdl.exists(int'(a))) return mdl[int'(a)];
        return 9'h000;
    endfunction

    function automatic bit model_written(input logic [15:0] a);
        return mdl.exists(int'(a));
    endfunction

    function automatic void bump_err();
        if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
    endfunction

    task automatic set_inj(input bit inj);
`ifdef PARITY_CHECK_EN
        par_inject = inj;
`else
        if (inj) $display("note: injection ignored in this build");
`endif
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d,
                            input bit inj);
        @(negedge clk);
        write = 1'b1; read = 1'b0; address = a; data_in = d;
        set_inj(inj);
        @(negedge clk);
        write = 1'b0;
        set_inj(1'b0);
        mdl[int'(a)] = good_word(d) ^ {inj, 8'h00};
    endtask

    // Returns at the negedge where the response should be visible
    task automatic issue_read(input logic [15:0] a);
        @(negedge clk);
        read = 1'b1; write = 1'b0; address = a;
        @(negedge clk);
        read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; write = 0; read = 0; address = 0; data_in = 0;
        set_inj(1'b0);
        exp_err = 16'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nchk++;
        if ({data_out, rd_valid, uninit_rd, prot_err} !== 12'h000) begin
            errs++;
            $display("FAIL reset_outs: got %h/%b%b%b want 000/000",
                     data_out, rd_valid, uninit_rd, prot_err);
        end
        nchk++;
        if (error_count !== 16'd0) begin
            errs++;
            $display("FAIL reset_cnt: got %h want 0000", error_count);
        end
    endtask

    task automatic test_basic();
        logic [8:0] exp;
        do_write(16'h1234, 8'hA5, 1'b0);
        exp = model_rd(16'h1234);
        issue_read(16'h1234);
        nchk++;
        if (data_out !== exp || rd_valid !== 1'b1 || uninit_rd !== 1'b0) begin
            errs++;
            $display("FAIL basic_rd: got %h v%b u%b want %h v1 u0",
                     data_out, rd_valid, uninit_rd, exp);
        end
        nchk++;
        if (exp !== 9'h0A5) begin
            errs++;
            $display("FAIL basic_model: got %h want 0a5", exp);
        end
        @(negedge clk);
        nchk++;
        if (rd_valid !== 1'b0 || data_out !== exp) begin
            errs++;
            $display("FAIL basic_hold: got %h v%b want %h v0",
                     data_out, rd_valid, exp);
        end
    endtask

    task automatic test_wrap_uninit();
        do_write(16'hFFFF, 8'h07, 1'b0);
        issue_read(16'hFFFF);
        nchk++;
        if (data_out !== 9'h107 || rd_valid !== 1'b1 || uninit_rd !== 1'b0) begin
            errs++;
            $display("FAIL wrap_rd: got %h v%b u%b want 107 v1 u0",
                     data_out, rd_valid, uninit_rd);
        end
        issue_read(16'h0001);
        nchk++;
        if (data_out !== 9'h000 || rd_valid !== 1'b1 || uninit_rd !== 1'b1) begin
            errs++;
            $display("FAIL uninit_rd: got %h v%b u%b want 000 v1 u1",
                     data_out, rd_valid, uninit_rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [6];
        logic [15:0] order [6];
        logic [8:0]  exp [6];
        logic [15:0] a, t;
        bit dup;
        for (int i = 0; i < 6; i++) begin
            do begin
                a = 16'($urandom);
                dup = model_written(a);
                for (int j = 0; j < i; j++) if (addrs[j] == a) dup = 1;
            end while (dup);
            addrs[i] = a;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            write = 1'b1; read = 1'b0;
            address = addrs[i]; data_in = 8'($urandom);
            mdl[int'(addrs[i])] = good_word(data_in);
        end
        for (int i = 0; i < 6; i++) order[i] = addrs[i];
        for (int i = 5; i > 0; i--) begin
            int k;
            k = $urandom_range(i, 0);
            t = order[i]; order[i] = order[k]; order[k] = t;
        end
        for (int i = 0; i < 6; i++) exp[i] = model_rd(order[i]);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                nchk++;
                if (rd_valid !== 1'b1 || data_out !== exp[k-2]
                    || uninit_rd !== 1'b0) begin
                    errs++;
                    $display("FAIL b2b_rd%0d: got %h v%b u%b want %h v1 u0",
                             k - 2, data_out, rd_valid, uninit_rd, exp[k-2]);
                end
            end
            write = 1'b0;
            if (k < 6) begin
                read = 1'b1; address = order[k];
            end else begin
                read = 1'b0;
            end
        end
        nchk++;
        if (error_count !== exp_err) begin
            errs++;
            $display("FAIL b2b_cnt: got %h want %h", error_count, exp_err);
        end
    endtask

    task automatic test_parity();
`ifdef PARITY_CHECK_EN
        do_write(16'h0300, 8'h03, 1'b1);
        issue_read(16'h0300);
        bump_err();
        nchk++;
        if (data_out !== 9'h103 || par_err !== 1'b1 || rd_valid !== 1'b1) begin
            errs++;
            $display("FAIL par_rd: got %h p%b v%b want 103 p1 v1",
                     data_out, par_err, rd_valid);
        end
        nchk++;
        if (error_count !== exp_err) begin
            errs++;
            $display("FAIL par_cnt: got %h want %h", error_count, exp_err);
        end
        do_write(16'h0301, 8'h03, 1'b0);
        issue_read(16'h0301);
        nchk++;
        if (data_out !== 9'h003 || par_err !== 1'b0) begin
            errs++;
            $display("FAIL par_clean: got %h p%b want 003 p0",
                     data_out, par_err);
        end
`endif
    endtask

    task automatic test_collision();
        @(negedge clk);
        write = 1'b1; read = 1'b1; address = 16'h0010; data_in = 8'h55;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        @(negedge clk);
        bump_err();
        nchk++;
        if (prot_err !== 1'b1 || rd_valid !== 1'b0) begin
            errs++;
            $display("FAIL coll_pulse: got p%b v%b want p1 v0",
                     prot_err, rd_valid);
        end
        nchk++;
        if (error_count !== exp_err) begin
            errs++;
            $display("FAIL coll_cnt: got %h want %h", error_count, exp_err);
        end
        @(negedge clk);
        nchk++;
        if (prot_err !== 1'b0) begin
            errs++;
            $display("FAIL coll_drop: got %b want 0", prot_err);
        end
        issue_read(16'h0010);
        nchk++;
        if (uninit_rd !== 1'b1 || data_out !== 9'h000 || rd_valid !== 1'b1) begin
            errs++;
            $display("FAIL coll_nowr: got %h v%b u%b want 000 v1 u1",
                     data_out, rd_valid, uninit_rd);
        end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        force dut.error_count = 16'hFFFF;
        #1;
        release dut.error_count;
        exp_err = 16'hFFFF;
        @(negedge clk);
        write = 1'b1; read = 1'b1; address = 16'h0011; data_in = 8'h01;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        @(negedge clk);
        bump_err();
        nchk++;
        if (prot_err !== 1'b1 || error_count !== exp_err) begin
            errs++;
            $display("FAIL sat_cnt: got p%b %h want p1 %h",
                     prot_err, error_count, exp_err);
        end
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        seen = 0;
        @(negedge clk);
        read = 1'b1; write = 1'b0; address = 16'h0020;
        @(posedge clk);
        #1;
        read = 1'b0;
        rst = 1'b1;
        mdl.delete();
        exp_err = 16'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rd_valid !== 1'b0) seen = 1;
        end
        nchk++;
        if (seen) begin
            errs++;
            $display("FAIL rst_drop: got rd_valid 1 want 0");
        end
        nchk++;
        if ({data_out, uninit_rd, prot_err} !== 11'h000 || error_count !== 16'd0) begin
            errs++;
            $display("FAIL rst_outs: got %h u%b p%b c%h want 000 u0 p0 c0000",
                     data_out, uninit_rd, prot_err, error_count);
        end
        issue_read(16'h1234);
        nchk++;
        if (uninit_rd !== 1'b1 || data_out !== 9'h000) begin
            errs++;
            $display("FAIL rst_flags: got %h u%b want 000 u1",
                     data_out, uninit_rd);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_uninit();
        test_back_to_back();
        test_parity();
        test_collision();
        test_saturate();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/parity_mem_responder.md
Name: parity_mem_responder

Overview:
- Synthesizable responder end of the team's parity-memory read/write interface; the counterpart of the memory testbench initiators.
- Accepts single-cycle write/read strobes with address and byte data.
- Stores each byte with an even-parity bit; returns 9-bit words {parity, data} one cycle after a read.
- Flags protocol violations (simultaneous read and write) and reads of never-written addresses; keeps a saturating error counter visible to the bench.

Parameters:
- ADDR_W, 16, address width; storage depth is 2**ADDR_W words.
- ERR_CNT_W, 16, width of error_count.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- write  input  1  write strobe, sampled each clk
- read  input  1  read strobe, sampled each clk
- address  input  ADDR_W  target address for write or read
- data_in  input  8  write data
- data_out  output  9  read response {^data, data}; holds last value when rd_valid=0
- rd_valid  output  1  one-cycle pulse: data_out carries a new response
- uninit_rd  output  1  one-cycle pulse with rd_valid: address was never written since reset
- prot_err  output  1  one-cycle pulse: write and read both high in the same cycle
- error_count  output  ERR_CNT_W  saturating count of prot_err events (plus par_err events when the optional feature is enabled)

Behaviour:
- Reset (async assert, sync release): data_out=9'h000, rd_valid=0, uninit_rd=0, prot_err=0, error_count=0, all per-address written flags cleared. Storage contents are not reset.
- State machine: IDLE, RESP, ERR.
  - IDLE→RESP on an accepted read.
  - IDLE→ERR on a collision.
  - RESP/ERR return to IDLE after one cycle unless a new command arrives in that cycle; back-to-back commands are accepted every cycle.
- Write only (write=1, read=0):
  - mem[address] <= {^data_in, data_in}; written flag set.
  - No output change.
  - Zero-cycle acceptance.
- Read only (read=1, write=0):
  - Edge N samples the address.
  - Edge N+1 drives data_out=mem[address] and rd_valid=1, giving 1-cycle latency.
  - Unwritten address: data_out=9'h000 and uninit_rd=1 together with rd_valid.
- Write at edge N then read of the same address at edge N+1: returns the newly written word. There is no read-before-write hazard.
- Collision (write=1, read=1):
  - Neither operation is performed.
  - prot_err=1 at N+1.
  - error_count increments by 1; it saturates at all-ones and does not wrap.
  - rd_valid stays 0.
- Neither strobe: no state change; pulses deassert.
- Address wrap: addresses are used modulo 2**ADDR_W; all-ones is a legal address.
- Reset asserted mid-read: the pending response is dropped and rd_valid stays 0 after release.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- When defined:
  - Adds input par_inject (1) and output par_err (1).
  - A write with par_inject=1 stores the inverted parity bit.
  - Every read recomputes ^data against the stored parity bit. On mismatch, par_err pulses with rd_valid and error_count increments (saturating). data_out still returns the stored word unmodified.
- When undefined: the ports are absent, no check is made, and behaviour is otherwise identical.

Decomposition:
- Package my_mem_pkg:
  - DATA_W=8, WORD_W=9.
  - typedef logic [WORD_W-1:0] mem_word_t.
  - typedef enum {IDLE, RESP, ERR} resp_state_t.
  - Function make_word(data) returning {^data, data}.
- One sub-module, parity_mem_array: a 2**ADDR_W x WORD_W synchronous-write, registered-read storage array plus the written-flag bit vector with async clear.
- FSM, collision detection, and counters live in parity_mem_responder.

Test Plan:
- Write 16'h1234/8'hA5, then read 16'h1234 → next cycle data_out=9'h0A5 (parity 0), rd_valid=1, uninit_rd=0.
- Write 16'hFFFF/8'h07, then read 16'hFFFF → data_out=9'h107. Also read never-written 16'h0001 → data_out=9'h000 with rd_valid=1 and uninit_rd=1.
- Assert write=1 and read=1 together with address 16'h0010/8'h55 → prot_err pulse, error_count=1, rd_valid=0, and a later read of 16'h0010 reports uninit_rd=1. Preload error_count=2**ERR_CNT_W-1 by forcing; a further collision leaves it unchanged.
- Six random address/data writes, then reads in shuffled order, back-to-back with no idle cycles → every response equals {^d, d} and error_count=0.
- Issue a read of 16'h0020, then assert rst on the next edge → no rd_valid after release, and all outputs hold their reset values.
- (PARITY_CHECK_EN) Write 8'h03 with par_inject=1, then read → data_out=9'h103, par_err=1, error_count incremented by 1.
